// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one single-cycle ALU
// The result register is tagged with the requester ID and drained through its own valid/ready.

module alu #(
  parameter int n = 32
) (
  input  logic [3:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] result,
  output logic         err
);
  localparam int SW = $clog2(n);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      4'b0000: result = a + b;
      4'b0001: result = a - b;
      4'b0010: result = a << b[SW-1:0];
      4'b0100: result = {{(n-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0110: result = {{(n-1){1'b0}}, (a < b)};
      4'b1000: result = a ^ b;
      4'b1010: result = a >> b[SW-1:0];
      4'b1011: result = $unsigned($signed(a) >>> b[SW-1:0]);
      4'b1100: result = a | b;
      4'b1110: result = a & b;
      default: err = 1'b1;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] rsp_data,
  output logic         rsp_err
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state_q;
  logic         last_grant_q;
  logic         rsp_id_q;
  logic [n-1:0] rsp_data_q;
  logic         rsp_err_q;

  logic         can_issue;
  logic         grant0, grant1;
  logic [3:0]   sel_op;
  logic [n-1:0] sel_a, sel_b;
  logic [n-1:0] alu_result_d;
  logic         alu_err_d;

  assign can_issue = (state_q == EMPTY) | rsp_ready;

  // With both valid, the requester that did not win last time gets the slot.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = grant0 & can_issue & nReset;
  assign req1_ready = grant1 & can_issue & nReset;

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  alu #(.n(n)) u_alu (
    .op     (sel_op),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_result_d),
    .err    (alu_err_d)
  );

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else if (req0_ready | req1_ready) begin
      state_q      <= FULL;
      last_grant_q <= req1_ready;
      rsp_id_q     <= req1_ready;
      rsp_data_q   <= alu_result_d;
      rsp_err_q    <= alu_err_d;
    end else if (rsp_ready) begin
      state_q <= EMPTY;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter
// Accepted requests push a model result; drained responses pop and compare.

module tb_alu_arbiter;
  logic        clock;
  logic        nReset;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int checks = 0;
  int errors = 0;

  alu_arbiter #(.n(32)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic rsp_t model(input logic id, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.id = id;
    r.err = 1'b0;
    r.data = 32'h0;
    case (op)
      4'd0:  r.data = a + b;
      4'd1:  r.data = a - b;
      4'd2:  r.data = a << b[4:0];
      4'd4:  r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  r.data = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r.data = a ^ b;
      4'd10: r.data = a >> b[4:0];
      4'd11: r.data = $signed(a) >>> b[4:0];
      4'd12: r.data = a | b;
      4'd14: r.data = a & b;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: expected readies (-1 = don't care), scoreboard pop/push.
  task automatic cyc(input int e0, input int e1);
    rsp_t exp_r;
    @(negedge clock);
    if (e0 >= 0) chk("req0_ready", req0_ready, e0[0]);
    if (e1 >= 0) chk("req1_ready", req1_ready, e1[0]);
    chk("ready_onehot", req0_ready & req1_ready, 1'b0);
    if (nReset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("rsp_without_request", rsp_valid, 1'b0);
      else begin
        exp_r = sb.pop_front();
        chk("rsp_id_err_data", {rsp_id, rsp_err, rsp_data}, exp_r);
      end
    end
    if (req0_ready) sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
    if (req1_ready) sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
    @(posedge clock);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    nReset = 1'b1;
    sb.delete();
  endtask

  initial begin
    nReset = 1'b0;
    rsp_ready = 1'b1;
    set0(1'b1, 4'd0, 32'h0, 32'h0);
    set1(1'b1, 4'd0, 32'h0, 32'h0);
    @(posedge clock);
    #1;
    do_reset();
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_err", rsp_err, 1'b0);

    // ADD wrap
    set1(1'b0, 4'd0, 32'h0, 32'h0);
    set0(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h1);
    cyc(1, 0);
    chk("add_rsp_valid", rsp_valid, 1'b1);
    chk("add_rsp_data", rsp_data, 32'h0);
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    cyc(0, 0);
    chk("drained_empty", rsp_valid, 1'b0);

    // Fairness: fresh reset so last_grant is 1 and req0 wins first
    do_reset();
    set0(1'b1, 4'd1, 32'd5, 32'd7);
    set1(1'b1, 4'd11, 32'h8000_0000, 32'd4);
    for (int i = 0; i < 6; i++) begin
      cyc(i % 2 == 0 ? 1 : 0, i % 2 == 0 ? 0 : 1);
      chk("no_bubble", rsp_valid, 1'b1);
    end
    chk("last_was_id1", rsp_id, 1'b1);
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    set1(1'b0, 4'd0, 32'h0, 32'h0);
    cyc(0, 0);

    // Backpressure
    rsp_ready = 1'b0;
    set1(1'b1, 4'd6, 32'd1, 32'hFFFF_FFFF);
    cyc(0, 1);
    set1(1'b0, 4'd0, 32'h0, 32'h0);
    set0(1'b1, 4'd12, 32'h12, 32'h21);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0);
      chk("stall_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 32'd1});
    end
    rsp_ready = 1'b1;
    cyc(1, 0);
    chk("stall_reload", {rsp_id, rsp_data}, {1'b0, 32'h33});
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    cyc(0, 0);

    // Unsupported opcode then AND
    set0(1'b1, 4'b0011, 32'd3, 32'd4);
    cyc(1, 0);
    chk("bad_op", {rsp_err, rsp_data}, {1'b1, 32'h0});
    set0(1'b1, 4'd14, 32'h0000_F0F0, 32'h0000_FF00);
    cyc(1, 0);
    chk("and_op", {rsp_err, rsp_data}, {1'b0, 32'h0000_F000});
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    cyc(0, 0);

    // Withdrawal while stalled: last_grant stays 0, so req1 wins next
    rsp_ready = 1'b0;
    set0(1'b1, 4'd8, 32'hAAAA_0000, 32'h0000_5555);
    cyc(1, 0);
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    set1(1'b1, 4'd0, 32'd9, 32'd9);
    cyc(0, 0);
    set1(1'b0, 4'd0, 32'h0, 32'h0);
    cyc(0, 0);
    rsp_ready = 1'b1;
    set0(1'b1, 4'd10, 32'hF000_0000, 32'd8);
    set1(1'b1, 4'd4, 32'hFFFF_FFFF, 32'd1);
    cyc(0, 1);
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    set1(1'b0, 4'd0, 32'h0, 32'h0);
    cyc(0, 0);

    // Reset mid-operation discards the held result
    rsp_ready = 1'b0;
    set0(1'b1, 4'd2, 32'd1, 32'd5);
    cyc(1, 0);
    chk("held_before_reset", rsp_valid, 1'b1);
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    nReset = 1'b0;
    cyc(0, 0);
    chk("midop_reset_valid", rsp_valid, 1'b0);
    nReset = 1'b1;
    sb.delete();
    rsp_ready = 1'b1;
    set0(1'b1, 4'd0, 32'd100, 32'd23);
    set1(1'b1, 4'd1, 32'd0, 32'd1);
    cyc(1, 0);
    cyc(0, 1);
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    set1(1'b0, 4'd0, 32'h0, 32'h0);
    cyc(0, 0);

    // Random mix with random drain
    for (int i = 0; i < 60; i++) begin
      set0($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom, $urandom);
      set1($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom, $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc(-1, -1);
    end
    set0(1'b0, 4'd0, 32'h0, 32'h0);
    set1(1'b0, 4'd0, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    cyc(0, 0);
    cyc(0, 0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("final_rsp_valid", rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer `alu` datapath between two requesters, for example the execute stage and the branch/address unit. Each requester uses a valid/ready handshake; a round-robin arbiter grants one request per cycle. The granted operation is computed by an internal `alu` instance and its result is captured into a one-entry output register. That register is tagged with the requester ID and drained through its own valid/ready handshake.

## Interface
Parameters:
- `n`, 32, operand/result width; passed to the `alu` instance.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `nReset`  in  1  reset, synchronous, active-low.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_op`  in  4  requester 0 ALU opcode (ALU encoding).
- `req0_a`, `req0_b`  in  n  requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`  same as requester 0, for requester 1.
- `rsp_valid`  out  1  result register holds a result.
- `rsp_ready`  in  1  consumer takes result this cycle.
- `rsp_id`  out  1  requester that issued the held result.
- `rsp_data`  out  n  held result.
- `rsp_err`  out  1  held result came from an unsupported opcode.

## Operation
- Supported opcodes (ALU encoding):
  - 0000 ADD
  - 0001 SUB
  - 0010 SLL
  - 0100 SLT
  - 0110 SLTU
  - 1000 XOR
  - 1010 SRL
  - 1011 SRA
  - 1100 OR
  - 1110 AND
- Any other opcode is accepted normally. Its response has `rsp_err`=1 and `rsp_data`=0.
- Operands pass to the ALU unmodified. Results are n bits; ADD/SUB wrap modulo 2^n.
- Output register state machine:
  - EMPTY (`rsp_valid`=0): a grant moves to FULL.
  - FULL (`rsp_valid`=1): `rsp_ready`=1 with no grant moves to EMPTY. `rsp_ready`=1 with a grant stays FULL and loads the new result. `rsp_ready`=0 holds.
- `can_issue` = !`rsp_valid` | `rsp_ready`.
- Arbitration uses the register `last_grant`, which resets to 1.
  - Only one `reqX_valid` high: grant X.
  - Both high: grant the requester ≠ `last_grant`.
  - `last_grant` updates only on an actual grant (grant & `can_issue`).
- `reqX_ready` = grant_X & `can_issue`. It is combinational and may depend on both valids; it never depends on `rsp_ready` of a later cycle.
- A requester must hold valid and operands stable until ready. Dropping valid without ready withdraws the request with no side effects.
- At most one `reqX_ready` is high per cycle.
- The held `rsp_id`/`rsp_data`/`rsp_err` stay stable while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Reset (`nReset` low at a rising edge):
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `last_grant`=1.
  - `req0_ready`=`req1_ready`=0 during any cycle in which `nReset` is low.
  - Reset mid-operation discards any held result without signalling it.
- Latency is 1 cycle. A request accepted at edge t appears with `rsp_valid`=1 after edge t, readable in cycle t+1.
- Throughput is 1 result/cycle when `rsp_ready` is held high. Simultaneous drain and issue in the same cycle loses no bubble.
- With `rsp_ready` low and FULL, both readies are 0. Arbitration is re-evaluated every cycle, so the pending winner is not locked.
- Fairness: with both valids continuously high and `rsp_ready`=1, grants alternate 0,1,0,1… Max wait is 1 grant to the other requester.

## Test plan
- Reset, then `req0` ADD 0xFFFFFFFF+0x00000001 with `rsp_ready`=1 → `req0_ready`=1 in cycle 0; cycle 1: `rsp_valid`=1, `rsp_id`=0, `rsp_data`=0x00000000, `rsp_err`=0.
- Both requesters valid continuously: `req0` SUB 5−7, `req1` SRA 0x80000000 by 4, `rsp_ready`=1 → accepts alternate starting with 0. Results alternate 0xFFFFFFFE (id 0) and 0xF8000000 (id 1), one per cycle, no bubbles.
- Backpressure: issue `req1` SLTU 1<0xFFFFFFFF, hold `rsp_ready`=0 for 5 cycles while `req0` valid → `rsp_data`=1, `rsp_id`=1 stable. `req0_ready`=0 throughout. First cycle with `rsp_ready`=1: `req0_ready`=1 and the new result loads the next cycle.
- Unsupported opcode 0011 from `req0` with A=3, B=4 → `rsp_err`=1, `rsp_data`=0. A following AND 0xF0F0&0xFF00 gives `rsp_err`=0, `rsp_data`=0x0000F000.
- Withdrawal: `req1_valid` high one cycle while FULL and stalled, then low → no response generated and `last_grant` unchanged. The next simultaneous request is won per the prior `last_grant`.
- Reset mid-operation: `rsp_valid`=1 held, assert `nReset` low for one edge → `rsp_valid`=0 after that edge. After reset release, simultaneous requests grant `req0` first.
